// File: rtl/decode_round_sequencer.sv
// Sequences one decoding round: load a syndrome, settle, bracket growth, then stream defects.
// Optional early stop on grid convergence: define DECODE_ROUND_SEQUENCER_EARLY_STOP_EN.
module decode_round_sequencer #(
  parameter int GRID_WIDTH_X       = 5,
  parameter int GRID_WIDTH_Z       = 4,
  parameter int MATCH_VALUE_WIDTH  = 6,
  parameter int INDEX_WIDTH        = 5,
  parameter int LOAD_SETTLE_CYCLES = 100,
  parameter int OFFER_CYCLES       = 2500,
  parameter int COUNTER_WIDTH      = 12
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  round_valid,
  output logic                                                  round_ready,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0]                  round_syndrome,
  output logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0]                  grid_measurement_value,
  output logic                                                  grid_measurement_valid,
  output logic                                                  grid_start_offer,
  output logic                                                  grid_stop_offer,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0]                  grid_measurement,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z*MATCH_VALUE_WIDTH-1:0] grid_match_value,
  input  logic                                                  grid_converged,
  output logic                                                  result_valid,
  input  logic                                                  result_ready,
  output logic [INDEX_WIDTH-1:0]                                result_index,
  output logic [MATCH_VALUE_WIDTH-1:0]                          result_match,
  output logic                                                  result_last,
  output logic                                                  round_done,
  output logic                                                  busy
);

  localparam int NODES = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int MW    = MATCH_VALUE_WIDTH;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_SETTLE  = 4'd2;
  localparam logic [3:0] S_START   = 4'd3;
  localparam logic [3:0] S_GROW    = 4'd4;
  localparam logic [3:0] S_STOP    = 4'd5;
  localparam logic [3:0] S_CAPTURE = 4'd6;
  localparam logic [3:0] S_DRAIN   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [NODES-1:0]         measValue_q, measValue_d;
  logic [NODES-1:0]         snapMeas_q, snapMeas_d;
  logic [NODES*MW-1:0]      snapMatch_q, snapMatch_d;
  logic [INDEX_WIDTH-1:0]   resIndex_q, resIndex_d;
  logic [MW-1:0]            resMatch_q, resMatch_d;
  logic                     resLast_q, resLast_d;
  logic                     roundReady_q, busy_q, measValid_q;
  logic                     startOffer_q, stopOffer_q, resValid_q, roundDone_q;
  logic                     earlyStop;

  logic [INDEX_WIDTH:0]     capFirst, drnNext;
  logic                     capMore, drnMore;

  // Lowest set bit at or above lo, returned as {found, index}.
  function automatic logic [INDEX_WIDTH:0] findFrom(input logic [NODES-1:0] v, input int lo);
    logic [INDEX_WIDTH:0] r;
    r = '0;
    for (int j = NODES - 1; j >= 0; j--) begin
      if (v[j] && (j >= lo)) r = {1'b1, INDEX_WIDTH'(j)};
    end
    return r;
  endfunction

  function automatic logic anyFrom(input logic [NODES-1:0] v, input int lo);
    logic r;
    r = 1'b0;
    for (int j = 0; j < NODES; j++) begin
      if (v[j] && (j >= lo)) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    capFirst = findFrom(grid_measurement, 0);
    capMore  = anyFrom(grid_measurement, int'(capFirst[INDEX_WIDTH-1:0]) + 1);
    drnNext  = findFrom(snapMeas_q, int'(resIndex_q) + 1);
    drnMore  = anyFrom(snapMeas_q, int'(drnNext[INDEX_WIDTH-1:0]) + 1);
  end

`ifdef DECODE_ROUND_SEQUENCER_EARLY_STOP_EN
  logic [2:0] convRun_q, convRun_d;

  // Length of the current run of converged cycles inside GROW, saturating at 4.
  always_comb begin
    convRun_d = '0;
    if ((state_q == S_GROW) && grid_converged) begin
      convRun_d = (convRun_q == 3'd4) ? 3'd4 : convRun_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) convRun_q <= '0;
    else        convRun_q <= convRun_d;
  end

  assign earlyStop = grid_converged && (convRun_q >= 3'd3) &&
                     (cnt_q >= COUNTER_WIDTH'(7));
`else
  logic unused_converged;
  assign unused_converged = grid_converged;
  assign earlyStop        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    measValue_d = measValue_q;
    snapMeas_d  = snapMeas_q;
    snapMatch_d = snapMatch_q;
    resIndex_d  = resIndex_q;
    resMatch_d  = resMatch_q;
    resLast_d   = resLast_q;
    case (state_q)
      S_IDLE: begin
        if (round_valid && roundReady_q) begin
          measValue_d = round_syndrome;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == COUNTER_WIDTH'(LOAD_SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_GROW;
      end
      S_GROW: begin
        if ((cnt_q == COUNTER_WIDTH'(OFFER_CYCLES - 1)) || earlyStop) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      S_STOP: state_d = S_CAPTURE;
      // The first beat is formed straight from the live grid outputs on the snapshot edge.
      S_CAPTURE: begin
        snapMeas_d  = grid_measurement;
        snapMatch_d = grid_match_value;
        if (capFirst[INDEX_WIDTH]) begin
          resIndex_d = capFirst[INDEX_WIDTH-1:0];
          resMatch_d = grid_match_value[capFirst[INDEX_WIDTH-1:0]*MW +: MW];
          resLast_d  = !capMore;
          state_d    = S_DRAIN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (result_ready) begin
          if (resLast_q) begin
            resIndex_d = '0;
            resMatch_d = '0;
            resLast_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            resIndex_d = drnNext[INDEX_WIDTH-1:0];
            resMatch_d = snapMatch_q[drnNext[INDEX_WIDTH-1:0]*MW +: MW];
            resLast_d  = !drnMore;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flag outputs are registered from the next state so each aligns with its state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      measValue_q  <= '0;
      snapMeas_q   <= '0;
      snapMatch_q  <= '0;
      resIndex_q   <= '0;
      resMatch_q   <= '0;
      resLast_q    <= 1'b0;
      roundReady_q <= 1'b1;
      busy_q       <= 1'b0;
      measValid_q  <= 1'b0;
      startOffer_q <= 1'b0;
      stopOffer_q  <= 1'b0;
      resValid_q   <= 1'b0;
      roundDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      measValue_q  <= measValue_d;
      snapMeas_q   <= snapMeas_d;
      snapMatch_q  <= snapMatch_d;
      resIndex_q   <= resIndex_d;
      resMatch_q   <= resMatch_d;
      resLast_q    <= resLast_d;
      roundReady_q <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      measValid_q  <= (state_d == S_LOAD);
      startOffer_q <= (state_d == S_START);
      stopOffer_q  <= (state_d == S_STOP);
      resValid_q   <= (state_d == S_DRAIN);
      roundDone_q  <= (state_d == S_DONE);
    end
  end

  assign round_ready            = roundReady_q;
  assign busy                   = busy_q;
  assign grid_measurement_value = measValue_q;
  assign grid_measurement_valid = measValid_q;
  assign grid_start_offer       = startOffer_q;
  assign grid_stop_offer        = stopOffer_q;
  assign result_valid           = resValid_q;
  assign result_index           = resIndex_q;
  assign result_match           = resMatch_q;
  assign result_last            = resLast_q;
  assign round_done             = roundDone_q;

endmodule

// File: doc/decode_round_sequencer.md
Name: decode_round_sequencer

Overview:
- Controller that drives one X-stabilizer decoding grid through a complete decoding round.
- Per round it accepts one syndrome snapshot, loads it into the grid with a single-cycle valid pulse, and waits a settle period.
- It then brackets the growth phase with start_offer/stop_offer pulses, snapshots the defect flags and match outputs, and streams one result per defect over a valid/ready port.
- Sits between the syndrome source and the grid top. It replaces hand-timed bench sequencing.

Parameters:
- GRID_WIDTH_X, 5, stabilizer columns.
- GRID_WIDTH_Z, 4, stabilizer rows.
- MATCH_VALUE_WIDTH, 6, width of one grid match value ({y,x}).
- INDEX_WIDTH, 5, width of node index; must satisfy 2^INDEX_WIDTH >= GRID_WIDTH_X*GRID_WIDTH_Z.
- LOAD_SETTLE_CYCLES, 100, idle cycles between load pulse and start_offer (min 1).
- OFFER_CYCLES, 2500, growth cycles between start_offer and stop_offer (min 1).
- COUNTER_WIDTH, 12, phase counter width; must hold max(LOAD_SETTLE_CYCLES, OFFER_CYCLES).

Ports (N = GRID_WIDTH_X*GRID_WIDTH_Z; node k = y*GRID_WIDTH_X + x):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- round_valid  in  1  syndrome round offered.
- round_ready  out  1  sequencer can accept a round.
- round_syndrome  in  N  syndrome bit per node.
- grid_measurement_value  out  N  to grid measurement_value_in_y_x.
- grid_measurement_valid  out  1  to every grid measurement_valid_in_y_x.
- grid_start_offer  out  1  to grid start_offer.
- grid_stop_offer  out  1  to grid stop_offer.
- grid_measurement  in  N  grid defect flags.
- grid_match_value  in  N*MATCH_VALUE_WIDTH  grid match values; node k occupies bits [k*MW +: MW].
- grid_converged  in  1  grid reports no further growth (used only with EARLY_STOP_EN).
- result_valid  out  1  result beat present.
- result_ready  in  1  consumer accepts the beat.
- result_index  out  INDEX_WIDTH  node index k of the defect.
- result_match  out  MATCH_VALUE_WIDTH  match value of that node.
- result_last  out  1  final beat of the round.
- round_done  out  1  one-cycle pulse when the round completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except round_ready=1; counters and snapshot registers cleared.
- All outputs are registered. Reset asserted in any state aborts the round immediately. No partial results survive.
- Every pulse below is exactly one cycle wide.
- IDLE: round_ready=1.
  - round_valid&&round_ready at edge T latches round_syndrome into grid_measurement_value, which is held until the next accept.
  - Next state LOAD.
- LOAD (cycle T+1): grid_measurement_valid=1; round_ready=0 from T+1 until the return to IDLE. Next state SETTLE.
- SETTLE: exactly LOAD_SETTLE_CYCLES cycles. Next state START.
- START: grid_start_offer=1. Next state GROW.
- GROW: exactly OFFER_CYCLES cycles. The counter loads 0 on entry and exits when it reaches OFFER_CYCLES-1. Next state STOP.
- STOP: grid_stop_offer=1. Next state CAPTURE.
- CAPTURE: on this cycle's edge, snapshot grid_measurement and grid_match_value. Scan pointer set to the lowest set defect bit.
  - No defects: go directly to DONE.
  - Otherwise: go to DRAIN.
- DRAIN: present defects in ascending k.
  - result_valid=1; result_index=k; result_match=snapshot slice k.
  - result_last=1 on the highest set defect.
  - Beats advance only on result_valid&&result_ready; all fields hold stable while ready=0.
  - The next set bit is found combinationally (priority search above the current k), so back-to-back beats are possible.
  - Accepting the last beat moves to DONE.
- DONE: round_done=1, busy=0 next cycle. Next state IDLE.
- Fixed latency: START occurs at T+2+LOAD_SETTLE_CYCLES; STOP occurs at T+3+LOAD_SETTLE_CYCLES+OFFER_CYCLES.
- round_valid while busy is ignored and produces no side effect.
- grid_converged is ignored unless EARLY_STOP_EN is defined.

Optional Feature:
- Macro DECODE_ROUND_SEQUENCER_EARLY_STOP_EN.
- Defined: in GROW, if grid_converged=1 for 4 consecutive cycles after at least 8 GROW cycles, go to STOP immediately. OFFER_CYCLES remains the upper bound.
- Undefined: GROW always lasts OFFER_CYCLES cycles; grid_converged is unused.

Test Plan:
- Defaults, syndrome bits k={0,1,12,13,15} (grid stub returns match=k+1) -> valid pulse at T+1, start at T+102, stop at T+2603; 5 beats index 0,1,12,13,15, match 1,2,13,14,16, last on 15 only; round_done next cycle.
- All-zero syndrome, stub reports no defects -> full pulse sequence, zero result beats, round_done the cycle after CAPTURE.
- result_ready held 0 for 7 cycles mid-stream, then toggled every cycle -> fields stable while stalled; no beat lost or duplicated.
- round_valid asserted continuously -> second round accepted only the cycle after round_done; round_ready=0 throughout the first round.
- reset=0 for 3 cycles mid-GROW -> all outputs 0, round_ready=1 immediately; a new round after release runs the full normal timing.
- With EARLY_STOP_EN, grid_converged=1 from GROW cycle 20 -> stop pulse at GROW cycle 24. Without the macro, same stimulus -> stop after 2500 GROW cycles.
